// File: rtl/sound_ram_arb_if.sv
//-----------------------------------------------------------------------------
// sound_ram_arb_if
//   Bundles the main-CPU port, the sound-CPU port, the sound RAM port and the
//   BUSY status of sound_ram_arb.
//
//   slave  : arbiter view (takes requests, drives acks, read data and RAM port)
//   master : requester / RAM-model view (drives requests, RAM read data)
//
//   Main port  : M_REQ, M_WE, M_ADDR[14:0] (word), M_BYTE_SEL[1:0],
//                M_DIN[15:0], M_DOUT[15:0], M_ACK
//   Sound port : Z_REQ, Z_WE, Z_ADDR[15:0] (byte), Z_DIN[7:0], Z_DOUT[7:0],
//                Z_ACK
//   RAM port   : RAM_ADDR[15:0], RAM_WE, RAM_WDATA[7:0], RAM_RDATA[7:0]
//   Status     : BUSY
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
interface sound_ram_arb_if;
   // main CPU (68k side, 16-bit word bus)
   logic        M_REQ;
   logic        M_WE;
   logic [14:0] M_ADDR;
   logic [1:0]  M_BYTE_SEL;
   logic [15:0] M_DIN;
   logic [15:0] M_DOUT;
   logic        M_ACK;
   // sound CPU (Z80 side, 8-bit byte bus)
   logic        Z_REQ;
   logic        Z_WE;
   logic [15:0] Z_ADDR;
   logic [7:0]  Z_DIN;
   logic [7:0]  Z_DOUT;
   logic        Z_ACK;
   // single-port 64 KiB sound RAM
   logic [15:0] RAM_ADDR;
   logic        RAM_WE;
   logic [7:0]  RAM_WDATA;
   logic [7:0]  RAM_RDATA;
   // status
   logic        BUSY;

   modport slave (
      input  M_REQ, M_WE, M_ADDR, M_BYTE_SEL, M_DIN,
      output M_DOUT, M_ACK,
      input  Z_REQ, Z_WE, Z_ADDR, Z_DIN,
      output Z_DOUT, Z_ACK,
      output RAM_ADDR, RAM_WE, RAM_WDATA,
      input  RAM_RDATA,
      output BUSY
   );

   modport master (
      output M_REQ, M_WE, M_ADDR, M_BYTE_SEL, M_DIN,
      input  M_DOUT, M_ACK,
      output Z_REQ, Z_WE, Z_ADDR, Z_DIN,
      input  Z_DOUT, Z_ACK,
      input  RAM_ADDR, RAM_WE, RAM_WDATA,
      output RAM_RDATA,
      input  BUSY
   );
endinterface

// File: rtl/sound_ram_arb.sv
//-----------------------------------------------------------------------------
// sound_ram_arb
//   Shares one single-port 64 KiB byte-wide sound RAM between the 16-bit main
//   CPU and the 8-bit sound CPU.
//
//   Main access : IDLE -> M_LO -> M_HI -> M_END -> IDLE
//                 low byte at {M_ADDR,0} in M_LO, high byte at {M_ADDR,1} in
//                 M_HI, M_ACK pulses in M_END (3 cycles after the grant cycle).
//   Sound access: IDLE -> Z_ACC -> Z_END -> IDLE
//                 Z_ACK pulses in Z_END (2 cycles after the grant cycle).
//
//   RAM read data arrives one cycle after the address, so each read byte is
//   captured on the clock edge that closes the cycle where it is presented.
//   Consequently M_DOUT[7:0] updates as M_END begins, M_DOUT[15:8] and Z_DOUT
//   update on the edge that ends the ACK cycle: the complete read word is
//   visible from the cycle after ACK (when the requester drops REQ).
//
//   Ports
//     CLK_32M : sole clock, rising edge
//     RESET_N : synchronous active-low reset
//     bus     : sound_ram_arb_if.slave (main port, sound port, RAM port, BUSY)
//
//   Configuration
//     SOUND_ARB_RR_EN : when defined, ties in IDLE go to the port not served
//                       last (round robin); otherwise main has fixed priority.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module sound_ram_arb (
   input  logic             CLK_32M,
   input  logic             RESET_N,
   sound_ram_arb_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      M_LO  = 3'd1,
      M_HI  = 3'd2,
      M_END = 3'd3,
      Z_ACC = 3'd4,
      Z_END = 3'd5
   } state_t;

   state_t      state, state_nxt;

   // request fields captured at grant; the low-byte cycle is driven straight
   // from the live inputs, so only what later states need is kept
   logic [14:0] lat_m_addr;
   logic        lat_m_rd;
   logic        lat_m_we_hi;
   logic [7:0]  lat_m_din_hi;
   logic        lat_z_rd;

   // registered outputs
   logic [15:0] ram_addr_q;
   logic        ram_we_q;
   logic [7:0]  ram_wdata_q;
   logic        m_ack_q;
   logic        z_ack_q;
   logic        busy_q;
   logic [15:0] m_dout_q;
   logic [7:0]  z_dout_q;

   // next values for the registered outputs
   logic [15:0] ram_addr_d;
   logic        ram_we_d;
   logic [7:0]  ram_wdata_d;
   logic        m_ack_d;
   logic        z_ack_d;
   logic        grant_m;
   logic        grant_z;
   logic        m_win;

   //--------------------------------------------------------------------------
   // Arbitration: decides whether main wins when IDLE looks at the requests
   //--------------------------------------------------------------------------
`ifdef SOUND_ARB_RR_EN
   // 1 = sound was served last; reset value lets main win the first tie
   logic last_z;

   assign m_win = bus.M_REQ && (!bus.Z_REQ || last_z);

   always_ff @(posedge CLK_32M) begin
      if (!RESET_N)
         last_z <= 1'b1;
      else if (grant_m)
         last_z <= 1'b0;
      else if (grant_z)
         last_z <= 1'b1;
   end
`else
   assign m_win = bus.M_REQ;
`endif

   //--------------------------------------------------------------------------
   // FSM state register
   //--------------------------------------------------------------------------
   always_ff @(posedge CLK_32M) begin
      if (!RESET_N)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   //--------------------------------------------------------------------------
   // Next state and next output values. RAM address/data hold their last
   // value when not being driven; the write strobe defaults low.
   //--------------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      grant_m     = 1'b0;
      grant_z     = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_we_d    = 1'b0;
      m_ack_d     = 1'b0;
      z_ack_d     = 1'b0;

      case (state)
         IDLE: begin
            if (m_win) begin
               state_nxt   = M_LO;
               grant_m     = 1'b1;
               ram_addr_d  = {bus.M_ADDR, 1'b0};
               ram_wdata_d = bus.M_DIN[7:0];
               ram_we_d    = bus.M_WE & bus.M_BYTE_SEL[0];
            end else if (bus.Z_REQ) begin
               state_nxt   = Z_ACC;
               grant_z     = 1'b1;
               ram_addr_d  = bus.Z_ADDR;
               ram_wdata_d = bus.Z_DIN;
               ram_we_d    = bus.Z_WE;
            end
         end
         M_LO: begin
            state_nxt   = M_HI;
            ram_addr_d  = {lat_m_addr, 1'b1};
            ram_wdata_d = lat_m_din_hi;
            ram_we_d    = lat_m_we_hi;
         end
         M_HI: begin
            state_nxt = M_END;
            m_ack_d   = 1'b1;
         end
         M_END: begin
            state_nxt = IDLE;
         end
         Z_ACC: begin
            state_nxt = Z_END;
            z_ack_d   = 1'b1;
         end
         Z_END: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   //--------------------------------------------------------------------------
   // Output registers, request latches and read-data capture
   //--------------------------------------------------------------------------
   always_ff @(posedge CLK_32M) begin
      if (!RESET_N) begin
         ram_addr_q   <= '0;
         ram_we_q     <= 1'b0;
         ram_wdata_q  <= '0;
         m_ack_q      <= 1'b0;
         z_ack_q      <= 1'b0;
         busy_q       <= 1'b0;
         m_dout_q     <= '0;
         z_dout_q     <= '0;
         lat_m_addr   <= '0;
         lat_m_rd     <= 1'b0;
         lat_m_we_hi  <= 1'b0;
         lat_m_din_hi <= '0;
         lat_z_rd     <= 1'b0;
      end else begin
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
         m_ack_q     <= m_ack_d;
         z_ack_q     <= z_ack_d;
         busy_q      <= (state_nxt != IDLE);

         if (grant_m) begin
            lat_m_addr   <= bus.M_ADDR;
            lat_m_rd     <= ~bus.M_WE;
            lat_m_we_hi  <= bus.M_WE & bus.M_BYTE_SEL[1];
            lat_m_din_hi <= bus.M_DIN[15:8];
         end
         if (grant_z)
            lat_z_rd <= ~bus.Z_WE;

         // reads always fetch both bytes, whatever M_BYTE_SEL says
         if (state == M_HI && lat_m_rd)
            m_dout_q[7:0] <= bus.RAM_RDATA;
         if (state == M_END && lat_m_rd)
            m_dout_q[15:8] <= bus.RAM_RDATA;
         if (state == Z_END && lat_z_rd)
            z_dout_q <= bus.RAM_RDATA;
      end
   end

   //--------------------------------------------------------------------------
   // Port drive. The write strobe is gated by RESET_N so that a reset landing
   // in the middle of a main write stops the pending byte in the very cycle
   // reset is asserted, instead of one clock later.
   //--------------------------------------------------------------------------
   assign bus.RAM_ADDR  = ram_addr_q;
   assign bus.RAM_WE    = ram_we_q & RESET_N;
   assign bus.RAM_WDATA = ram_wdata_q;
   assign bus.M_ACK     = m_ack_q;
   assign bus.Z_ACK     = z_ack_q;
   assign bus.M_DOUT    = m_dout_q;
   assign bus.Z_DOUT    = z_dout_q;
   assign bus.BUSY      = busy_q;

endmodule
